// File: rtl/pe_row_ctrl.sv
// -----------------------------------------------------------------------------
// pe_row_ctrl
//
// Per-PE control unit for one row-stationary 1-D convolution pass. It loads an
// S-tap filter row into the PE's filter scratchpad, then slides an S-wide
// window over the ifmap row to produce E output partial sums. Each output
// starts from an incoming psum (ipsum) and leaves as an outgoing psum (opsum).
// The ifmap scratchpad is a circular buffer of depth S. After the first S
// beats, each new output needs only one fresh ifmap beat.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_valid/cfg_ready      pass configuration handshake (ready only in IDLE)
//   cfg_fltr_len             S, filter row length (1..MAX_S)
//   cfg_ofmap_len            E, output row length (1..MAX_E)
//   cfg_err                  one-cycle pulse after a rejected configuration
//   fltr_valid/fltr_ready    filter beat stream
//   fltr_wr_en/fltr_wr_addr  filter scratchpad write port
//   ifmap_valid/ifmap_ready  ifmap beat stream
//   ifmap_wr_en/_wr_addr     ifmap scratchpad write port
//   ifmap_rd_addr            ifmap scratchpad read address for the current MAC
//   fltr_rd_addr             filter scratchpad read address for the current MAC
//   ipsum_valid/ipsum_ready  incoming psum stream
//   opsum_valid/opsum_ready  outgoing psum stream
//   mac_en                   PE accumulator register enable
//   mult_seln                1 = product into adder, 0 = zero
//   acc_seln                 0 = add to ipsum, 1 = add to accumulator
//   busy                     controller is not idle
//   done                     one-cycle pulse when the last opsum is accepted
// -----------------------------------------------------------------------------
module pe_row_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_S      = 8,
    parameter int MAX_E      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(MAX_S):0]    cfg_fltr_len,
    input  logic [$clog2(MAX_E):0]    cfg_ofmap_len,
    output logic                      cfg_err,
    input  logic                      fltr_valid,
    output logic                      fltr_ready,
    output logic                      fltr_wr_en,
    output logic [$clog2(MAX_S)-1:0]  fltr_wr_addr,
    input  logic                      ifmap_valid,
    output logic                      ifmap_ready,
    output logic                      ifmap_wr_en,
    output logic [$clog2(MAX_S)-1:0]  ifmap_wr_addr,
    output logic [$clog2(MAX_S)-1:0]  ifmap_rd_addr,
    output logic [$clog2(MAX_S)-1:0]  fltr_rd_addr,
    input  logic                      ipsum_valid,
    output logic                      ipsum_ready,
    output logic                      opsum_valid,
    input  logic                      opsum_ready,
    output logic                      mac_en,
    output logic                      mult_seln,
    output logic                      acc_seln,
    output logic                      busy,
    output logic                      done
);

    localparam int SL_W   = $clog2(MAX_S) + 1;   // filter length field
    localparam int EL_W   = $clog2(MAX_E) + 1;   // output length field
    localparam int ADDR_W = $clog2(MAX_S);       // scratchpad address
    localparam int E_W    = $clog2(MAX_E);       // output index 0..E-1

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    // Catch nonsensical parameterisations at elaboration time.
    if (DATA_WIDTH < 1 || MAX_S < 2 || MAX_E < 1) begin : g_param_check
        $error("pe_row_ctrl: invalid parameter set");
    end

    logic [1:0]        r_state;
    logic [SL_W-1:0]   r_s;             // latched S
    logic [EL_W-1:0]   r_e_len;         // latched E
    logic [ADDR_W-1:0] r_k;             // tap index (also filter beat index in LOAD)
    logic [E_W-1:0]    r_e;             // output index
    logic [ADDR_W-1:0] r_base;          // e mod S, start of the window in the ring
    logic              r_opsum_valid;
    logic              r_cfg_err;

    logic              w_idle;
    logic              w_load;
    logic              w_compute;
    logic              w_drain;
    logic              w_cfg_bad;
    logic [SL_W-1:0]   w_s_m1;
    logic [EL_W-1:0]   w_e_m1;
    logic              w_k_last;
    logic              w_e_last;
    logic              w_need_ifmap;
    logic              w_fire;
    logic [SL_W-1:0]   w_sum;
    logic [SL_W-1:0]   w_ring;
    logic [ADDR_W-1:0] w_addr;
    logic [SL_W-1:0]   w_base_inc;
    logic [ADDR_W-1:0] w_base_next;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_load    = (r_state == ST_LOAD);
    assign w_compute = (r_state == ST_COMPUTE);
    assign w_drain   = (r_state == ST_DRAIN);

    assign w_cfg_bad = (cfg_fltr_len == '0) || (cfg_fltr_len > SL_W'(MAX_S)) ||
                       (cfg_ofmap_len == '0) || (cfg_ofmap_len > EL_W'(MAX_E));

    // S-1 and E-1 always fit the narrower counter widths once the config is legal.
    assign w_s_m1   = r_s - SL_W'(1);
    assign w_e_m1   = r_e_len - EL_W'(1);
    assign w_k_last = (r_k == w_s_m1[ADDR_W-1:0]);
    assign w_e_last = (EL_W'(r_e) == w_e_m1);

    // The first output fills the whole window; later outputs only need the
    // newest sample, which is consumed on the last tap.
    assign w_need_ifmap = (r_e == '0) || w_k_last;

    // A k == 0 step overwrites the accumulator, so it must wait until the
    // previous output has actually left (registered opsum_valid, not the
    // handshake), giving one bubble when the opsum drains immediately.
    assign w_fire = w_compute &&
                    (!w_need_ifmap || ifmap_valid) &&
                    ((r_k != '0) || (ipsum_valid && !r_opsum_valid));

    // (e + k) mod S with e tracked as e mod S; both operands are < S.
    assign w_sum  = {1'b0, r_base} + {1'b0, r_k};
    assign w_ring = (w_sum >= r_s) ? (w_sum - r_s) : w_sum;
    assign w_addr = w_ring[ADDR_W-1:0];

    assign w_base_inc  = {1'b0, r_base} + SL_W'(1);
    assign w_base_next = (w_base_inc == r_s) ? '0 : w_base_inc[ADDR_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_s           <= '0;
            r_e_len       <= '0;
            r_k           <= '0;
            r_e           <= '0;
            r_base        <= '0;
            r_opsum_valid <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_s     <= cfg_fltr_len;
                            r_e_len <= cfg_ofmap_len;
                            r_k     <= '0;
                            r_e     <= '0;
                            r_base  <= '0;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (fltr_valid) begin
                        if (w_k_last) begin
                            r_k     <= '0;
                            r_state <= ST_COMPUTE;
                        end else begin
                            r_k <= r_k + ADDR_W'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (w_fire) begin
                        if (w_k_last) begin
                            r_k <= '0;
                            if (w_e_last) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_e    <= r_e + E_W'(1);
                                r_base <= w_base_next;
                            end
                        end else begin
                            r_k <= r_k + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_opsum_valid && opsum_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // The PE accumulator holds the finished sum one cycle after the
            // last tap fires. A set never coincides with a pending opsum
            // because the k == 0 gate has already waited for it to drain.
            if (w_fire && w_k_last) begin
                r_opsum_valid <= 1'b1;
            end else if (opsum_ready) begin
                r_opsum_valid <= 1'b0;
            end
        end
    end

    // NOTE: every output gets a default first so no path through this block
    // can leave a signal unassigned and infer a latch.
    always_comb begin
        cfg_ready     = w_idle;
        busy          = !w_idle;
        cfg_err       = r_cfg_err;
        fltr_ready    = w_load;
        fltr_wr_en    = w_load && fltr_valid;
        fltr_wr_addr  = w_load ? r_k : '0;
        mac_en        = w_fire;
        mult_seln     = w_fire;
        acc_seln      = w_compute && (r_k != '0);
        ipsum_ready   = w_fire && (r_k == '0);
        ifmap_ready   = w_fire && w_need_ifmap;
        // The PE forwards the beat being written straight into the multiplier.
        ifmap_wr_en   = w_fire && w_need_ifmap;
        ifmap_wr_addr = w_compute ? w_addr : '0;
        ifmap_rd_addr = w_compute ? w_addr : '0;
        fltr_rd_addr  = w_compute ? r_k : '0;
        opsum_valid   = r_opsum_valid;
        done          = w_drain && r_opsum_valid && opsum_ready;
    end

endmodule

// File: tb/tb_pe_row_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_row_ctrl
//
// Directed bench for pe_row_ctrl. Whole passes are described by a table of
// {S, E, stall options, expected beat counts}. The per-MAC address/select
// sequence is compared against (e + k) mod S computed here. Rejected
// configurations come from a second table. Mid-pass reset is a hand sequence.
// -----------------------------------------------------------------------------
module tb_pe_row_ctrl;

    localparam int MAX_S = 8;
    localparam int MAX_E = 32;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_fltr_len;
    logic [5:0] cfg_ofmap_len;
    logic       cfg_err;
    logic       fltr_valid;
    logic       fltr_ready;
    logic       fltr_wr_en;
    logic [2:0] fltr_wr_addr;
    logic       ifmap_valid;
    logic       ifmap_ready;
    logic       ifmap_wr_en;
    logic [2:0] ifmap_wr_addr;
    logic [2:0] ifmap_rd_addr;
    logic [2:0] fltr_rd_addr;
    logic       ipsum_valid;
    logic       ipsum_ready;
    logic       opsum_valid;
    logic       opsum_ready;
    logic       mac_en;
    logic       mult_seln;
    logic       acc_seln;
    logic       busy;
    logic       done;

    pe_row_ctrl #(
        .DATA_WIDTH (16),
        .MAX_S      (MAX_S),
        .MAX_E      (MAX_E)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_fltr_len  (cfg_fltr_len),
        .cfg_ofmap_len (cfg_ofmap_len),
        .cfg_err       (cfg_err),
        .fltr_valid    (fltr_valid),
        .fltr_ready    (fltr_ready),
        .fltr_wr_en    (fltr_wr_en),
        .fltr_wr_addr  (fltr_wr_addr),
        .ifmap_valid   (ifmap_valid),
        .ifmap_ready   (ifmap_ready),
        .ifmap_wr_en   (ifmap_wr_en),
        .ifmap_wr_addr (ifmap_wr_addr),
        .ifmap_rd_addr (ifmap_rd_addr),
        .fltr_rd_addr  (fltr_rd_addr),
        .ipsum_valid   (ipsum_valid),
        .ipsum_ready   (ipsum_ready),
        .opsum_valid   (opsum_valid),
        .opsum_ready   (opsum_ready),
        .mac_en        (mac_en),
        .mult_seln     (mult_seln),
        .acc_seln      (acc_seln),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s;
        int e;
        int hold;        // cycles opsum_ready is held low at the first opsum
        bit toggle;      // toggle ifmap_valid while the first window fills
        int exp_ifmap;   // ifmap beats accepted
        int exp_ipsum;   // ipsum beats accepted
        int exp_opsum;   // opsum beats delivered
        int exp_mac;     // mac_en pulses
    } pass_vec_t;

    typedef struct {
        int s;
        int e;
        bit exp_err;
        bit exp_busy;
    } cfg_vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    int q_rd[$];
    int q_wa[$];
    int q_fr[$];
    int q_acc[$];
    int q_ml[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cfg_ready"},   cfg_ready, 1);
        check({tag, "_busy"},        busy, 0);
        check({tag, "_cfg_err"},     cfg_err, 0);
        check({tag, "_fltr_ready"},  fltr_ready, 0);
        check({tag, "_fltr_wr_en"},  fltr_wr_en, 0);
        check({tag, "_ifmap_ready"}, ifmap_ready, 0);
        check({tag, "_ifmap_wr_en"}, ifmap_wr_en, 0);
        check({tag, "_ipsum_ready"}, ipsum_ready, 0);
        check({tag, "_opsum_valid"}, opsum_valid, 0);
        check({tag, "_mac_en"},      mac_en, 0);
        check({tag, "_mult_seln"},   mult_seln, 0);
        check({tag, "_acc_seln"},    acc_seln, 0);
        check({tag, "_done"},        done, 0);
        check({tag, "_addrs"},       int'(fltr_wr_addr) + int'(ifmap_wr_addr) +
                                     int'(ifmap_rd_addr) + int'(fltr_rd_addr), 0);
    endtask

    task automatic configure(input int s, input int e);
        cfg_fltr_len  = 4'(s);
        cfg_ofmap_len = 6'(e);
        cfg_valid     = 1'b1;
        tick();
        cfg_valid     = 1'b0;
    endtask

    task automatic run_pass(input int pi, input pass_vec_t v);
        int  cyc = 0;
        int  post = 0;
        int  hold_left = 0;
        bit  hold_started = 0;
        bit  hs_seen = 0;
        bit  after_hs = 0;
        bit  got_done = 0;
        bit  idle_checked = 0;
        bit  in_compute;
        int  fltr_beats = 0;
        int  ifm_beats = 0;
        int  ipsum_beats = 0;
        int  opsum_hs = 0;
        int  mac_cnt = 0;
        int  done_cnt = 0;
        int  idx;
        string p;

        p = $sformatf("p%0d", pi);
        q_rd.delete(); q_wa.delete(); q_fr.delete(); q_acc.delete(); q_ml.delete();

        configure(v.s, v.e);
        check({p, "_cfg_accept_err"}, cfg_err, 0);
        check({p, "_cfg_accept_busy"}, busy, 1);

        while (cyc < 1000 && post < 2) begin
            // drive
            fltr_valid  = 1'b1;
            ipsum_valid = 1'b1;
            ifmap_valid = (v.toggle && ifm_beats < v.s) ? (cyc % 2 == 0) : 1'b1;
            if (v.hold > 0 && opsum_valid && !hold_started) begin
                hold_started = 1;
                hold_left    = v.hold;
            end
            opsum_ready = (hold_left == 0);
            if (hold_left > 0) hold_left--;
            #3;
            // sample
            in_compute = (fltr_beats == v.s) && busy;
            if (got_done && !idle_checked) begin
                check({p, "_after_done_cfg_ready"}, cfg_ready, 1);
                check({p, "_after_done_busy"}, busy, 0);
                idle_checked = 1;
            end
            if (fltr_wr_en) begin
                check($sformatf("%s_fltr_wr_addr[%0d]", p, fltr_beats), fltr_wr_addr, fltr_beats);
                fltr_beats++;
            end
            if (v.toggle && in_compute && ifm_beats < v.s)
                check($sformatf("%s_toggle_mac_c%0d", p, cyc), mac_en, ifmap_valid);
            if (mac_en) begin
                q_rd.push_back(ifmap_rd_addr);
                q_wa.push_back(ifmap_wr_en ? int'(ifmap_wr_addr) : -1);
                q_fr.push_back(fltr_rd_addr);
                q_acc.push_back(acc_seln);
                q_ml.push_back(mult_seln);
                mac_cnt++;
            end
            if (ifmap_wr_en) begin
                check($sformatf("%s_ifmap_wr_hs[%0d]", p, ifm_beats), ifmap_valid & ifmap_ready, 1);
                ifm_beats++;
            end
            if (ipsum_valid && ipsum_ready) begin
                check($sformatf("%s_drained_before_ipsum[%0d]", p, ipsum_beats), opsum_hs, ipsum_beats);
                ipsum_beats++;
            end
            if (opsum_valid)
                check($sformatf("%s_no_ipsum_with_opsum_c%0d", p, cyc), ipsum_ready, 0);
            if (v.hold > 0 && opsum_valid && !opsum_ready)
                check($sformatf("%s_stall_mac_c%0d", p, cyc), mac_en, 0);
            if (after_hs) begin
                check({p, "_ipsum_ready_after_hs"}, ipsum_ready, 1);
                after_hs = 0;
            end
            if (v.hold > 0 && opsum_valid && opsum_ready && !hs_seen) begin
                hs_seen  = 1;
                after_hs = 1;
            end
            if (opsum_valid && opsum_ready) opsum_hs++;
            if (done) begin
                done_cnt++;
                got_done = 1;
            end
            tick();
            cyc++;
            if (got_done) post++;
        end

        fltr_valid  = 1'b0;
        ifmap_valid = 1'b0;
        ipsum_valid = 1'b0;
        opsum_ready = 1'b0;

        check({p, "_done_seen"},   got_done, 1);
        check({p, "_done_count"},  done_cnt, 1);
        check({p, "_fltr_beats"},  fltr_beats, v.s);
        check({p, "_ifmap_beats"}, ifm_beats, v.exp_ifmap);
        check({p, "_ipsum_beats"}, ipsum_beats, v.exp_ipsum);
        check({p, "_opsum_beats"}, opsum_hs, v.exp_opsum);
        check({p, "_mac_count"},   mac_cnt, v.exp_mac);

        idx = 0;
        for (int e = 0; e < v.e; e++) begin
            for (int k = 0; k < v.s; k++) begin
                if (idx < q_rd.size()) begin
                    check($sformatf("%s_rd_addr[e%0d,k%0d]", p, e, k), q_rd[idx], (e + k) % v.s);
                    check($sformatf("%s_fltr_rd[e%0d,k%0d]", p, e, k), q_fr[idx], k);
                    check($sformatf("%s_acc_seln[e%0d,k%0d]", p, e, k), q_acc[idx], (k != 0) ? 1 : 0);
                    check($sformatf("%s_mult_seln[e%0d,k%0d]", p, e, k), q_ml[idx], 1);
                    check($sformatf("%s_wr_addr[e%0d,k%0d]", p, e, k), q_wa[idx],
                          (e == 0 || k == v.s - 1) ? (e + k) % v.s : -1);
                end
                idx++;
            end
        end
    endtask

    pass_vec_t passes[6];
    cfg_vec_t  bad_cfgs[5];
    pass_vec_t fresh;

    initial begin
        int mac_cnt;
        int cyc;

        // Hand-computed: ifmap beats = S + E - 1, ipsum = opsum = E, MACs = S*E.
        passes[0] = '{s: 3, e: 4,  hold: 0, toggle: 1'b0, exp_ifmap: 6,  exp_ipsum: 4,  exp_opsum: 4,  exp_mac: 12};
        passes[1] = '{s: 3, e: 2,  hold: 5, toggle: 1'b0, exp_ifmap: 4,  exp_ipsum: 2,  exp_opsum: 2,  exp_mac: 6};
        passes[2] = '{s: 3, e: 4,  hold: 0, toggle: 1'b1, exp_ifmap: 6,  exp_ipsum: 4,  exp_opsum: 4,  exp_mac: 12};
        passes[3] = '{s: 1, e: 4,  hold: 0, toggle: 1'b0, exp_ifmap: 4,  exp_ipsum: 4,  exp_opsum: 4,  exp_mac: 4};
        passes[4] = '{s: 8, e: 2,  hold: 0, toggle: 1'b0, exp_ifmap: 9,  exp_ipsum: 2,  exp_opsum: 2,  exp_mac: 16};
        passes[5] = '{s: 2, e: 32, hold: 0, toggle: 1'b0, exp_ifmap: 33, exp_ipsum: 32, exp_opsum: 32, exp_mac: 64};
        fresh     = '{s: 2, e: 3,  hold: 0, toggle: 1'b0, exp_ifmap: 4,  exp_ipsum: 3,  exp_opsum: 3,  exp_mac: 6};

        bad_cfgs[0] = '{s: 0, e: 4,  exp_err: 1'b1, exp_busy: 1'b0};
        bad_cfgs[1] = '{s: 9, e: 4,  exp_err: 1'b1, exp_busy: 1'b0};
        bad_cfgs[2] = '{s: 3, e: 0,  exp_err: 1'b1, exp_busy: 1'b0};
        bad_cfgs[3] = '{s: 3, e: 33, exp_err: 1'b1, exp_busy: 1'b0};
        bad_cfgs[4] = '{s: 15, e: 63, exp_err: 1'b1, exp_busy: 1'b0};

        rst           = 1'b1;
        cfg_valid     = 1'b0;
        cfg_fltr_len  = '0;
        cfg_ofmap_len = '0;
        fltr_valid    = 1'b0;
        ifmap_valid   = 1'b0;
        ipsum_valid   = 1'b0;
        opsum_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        for (int i = 0; i < 6; i++) begin
            run_pass(i, passes[i]);
        end

        for (int i = 0; i < 5; i++) begin
            configure(bad_cfgs[i].s, bad_cfgs[i].e);
            check($sformatf("cfg%0d_err", i), cfg_err, bad_cfgs[i].exp_err);
            check($sformatf("cfg%0d_busy", i), busy, bad_cfgs[i].exp_busy);
            check($sformatf("cfg%0d_ready", i), cfg_ready, 1);
            tick();
            check($sformatf("cfg%0d_err_clear", i), cfg_err, 0);
        end

        // Reset in the middle of COMPUTE at step (e=2, k=1) of an S=3, E=4 pass.
        configure(3, 4);
        fltr_valid  = 1'b1;
        ifmap_valid = 1'b1;
        ipsum_valid = 1'b1;
        opsum_ready = 1'b1;
        mac_cnt = 0;
        cyc = 0;
        while (mac_cnt < 7 && cyc < 200) begin
            #3;
            if (mac_en) mac_cnt++;
            tick();
            cyc++;
        end
        check("midrst_reached", mac_cnt, 7);
        #3;
        check("midrst_step_mac", mac_en, 1);
        check("midrst_step_rd_addr", ifmap_rd_addr, 0);
        check("midrst_step_fltr_rd", fltr_rd_addr, 1);
        rst = 1'b1;
        tick();
        check_idle_outputs("midrst");
        rst = 1'b0;
        fltr_valid  = 1'b0;
        ifmap_valid = 1'b0;
        ipsum_valid = 1'b0;
        opsum_ready = 1'b0;
        tick();
        check_idle_outputs("midrst_after");
        run_pass(6, fresh);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
